// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// 2**ADDR_W x DATA_W general-purpose register file with two combinational
// read ports, one synchronous write port and a per-register busy scoreboard
// that tracks registers with a write-back still pending.
//
// Register 0 is hard-wired to zero and is never marked busy.
//
// Optional build macro:
//   REGFILE_BYPASS_EN  - forward the write-back value (and the cleared busy
//                        state) to a read port addressing the register being
//                        written in the same cycle.
//
// Ports:
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   wr_en                 write-back strobe
//   wr_addr               write-back destination register
//   wr_data               write-back value
//   rd_addr_a, rd_addr_b  read-port addresses
//   rd_data_a, rd_data_b  read data (combinational)
//   issue_en              an instruction with a destination issues this cycle
//   issue_addr            destination register of the issuing instruction
//   busy_a, busy_b        read-port register has a pending write
//   busy_cnt              number of registers with a pending write (registered)
// ---------------------------------------------------------------------------
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NREG - 1);

    // -----------------------------------------------------------------------
    // Register storage. Entry 0 is cleared on reset and never written, so it
    // stays zero without any special read-side handling beyond the mux below.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] regs_reg [NREG];
    logic              wr_valid;

    assign wr_valid = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard. Per-register set/clear decode; a set on the same edge as a
    // clear of the same register wins, keeping the register busy.
    // -----------------------------------------------------------------------
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign set_vec[gi]   = 1'b0;
                assign clr_vec[gi]   = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign set_vec[gi]   = issue_en && (issue_addr == ADDR_W'(gi));
                assign clr_vec[gi]   = wr_en && (wr_addr == ADDR_W'(gi));
                assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Busy counter. At most one bit can rise (the issue target) and at most
    // one can fall (the write target) per edge, so the population count is
    // tracked incrementally instead of summing the vector every cycle.
    // -----------------------------------------------------------------------
    logic             cnt_inc;
    logic             cnt_dec;
    logic [CNT_W-1:0] busy_cnt_reg;
    logic [CNT_W-1:0] busy_cnt_next;

    assign cnt_inc = |(set_vec & ~busy_reg);
    assign cnt_dec = |(clr_vec & busy_reg & ~set_vec);

    always_comb begin
        busy_cnt_next = busy_cnt_reg;
        if (cnt_inc && !cnt_dec) begin
            if (busy_cnt_reg != CNT_MAX) begin
                busy_cnt_next = busy_cnt_reg + CNT_W'(1);
            end
        end else if (cnt_dec && !cnt_inc) begin
            if (busy_cnt_reg != '0) begin
                busy_cnt_next = busy_cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_reg <= '0;
        end else begin
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    // -----------------------------------------------------------------------
    // Read ports, built once per port from a small address/result table.
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr_v [2];
    logic [DATA_W-1:0] rd_data_v [2];
    logic              busy_v    [2];

    assign rd_addr_v[0] = rd_addr_a;
    assign rd_addr_v[1] = rd_addr_b;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic fwd_hit;
            logic issue_hit;

`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed during reset so every output reads 0.
            assign fwd_hit = rst_n && wr_valid && (rd_addr_v[gi] == wr_addr);
`else
            assign fwd_hit = 1'b0;
`endif
            assign issue_hit = issue_en && (issue_addr == rd_addr_v[gi]);

            always_comb begin
                rd_data_v[gi] = '0;
                busy_v[gi]    = 1'b0;
                if (fwd_hit) begin
                    rd_data_v[gi] = wr_data;
                    // The pending write completes now unless re-issued.
                    busy_v[gi]    = issue_hit;
                end else if (rd_addr_v[gi] != '0) begin
                    rd_data_v[gi] = regs_reg[rd_addr_v[gi]];
                    busy_v[gi]    = busy_reg[rd_addr_v[gi]];
                end
            end
        end
    endgenerate

    assign rd_data_a = rd_data_v[0];
    assign rd_data_b = rd_data_v[1];
    assign busy_a    = busy_v[0];
    assign busy_b    = busy_v[1];

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Randomised and directed stimulus against a behavioural model held in plain
// arrays. A negedge process compares every DUT output with the model each
// cycle; directed sequences add literal expectations on known scenarios.
// ---------------------------------------------------------------------------
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [ADDR_W-1:0] rd_addr_a = '0;
    logic [ADDR_W-1:0] rd_addr_b = '0;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              issue_en = 1'b0;
    logic [ADDR_W-1:0] issue_addr = '0;
    logic              busy_a;
    logic              busy_b;
    logic [ADDR_W:0]   busy_cnt;

    int vectors     = 0;
    int miscompares = 0;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [DATA_W-1:0] m_reg  [NREG];
    bit              m_busy [NREG];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
            if (wr_en) m_busy[wr_addr] = 1'b0;
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    end

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic bit [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] ra);
        if (BYPASS && rst_n && wr_en && wr_addr != 0 && ra == wr_addr) return wr_data;
        return m_reg[ra];
    endfunction

    function automatic bit exp_busy(input logic [ADDR_W-1:0] ra);
        if (BYPASS && rst_n && wr_en && wr_addr != 0 && ra == wr_addr)
            return issue_en && issue_addr == ra;
        return m_busy[ra];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cyc_rd_data_a", rd_data_a, exp_data(rd_addr_a));
        check("cyc_rd_data_b", rd_data_b, exp_data(rd_addr_b));
        check("cyc_busy_a", 32'(busy_a), 32'(exp_busy(rd_addr_a)));
        check("cyc_busy_b", 32'(busy_b), 32'(exp_busy(rd_addr_b)));
        check("cyc_busy_cnt", 32'(busy_cnt), 32'(model_count()));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input bit ie, input logic [ADDR_W-1:0] ia,
                         input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia;
        rd_addr_a = ra; rd_addr_b = rb;
    endtask

    initial begin
        // Reset and sweep all addresses.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt", 32'(busy_cnt), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            drive(0, 0, 0, 0, 0, 5'(i), 5'(NREG - 1 - i));
            #3;
            check("sweep_data_a", rd_data_a, 32'd0);
            check("sweep_busy_a", 32'(busy_a), 32'd0);
        end
        check("sweep_cnt", 32'(busy_cnt), 32'd0);

        // r0 write discarded, r31 write kept.
        drive(1, 5'd0, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(1, 5'd31, 32'h12345678, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd31);
        #3;
        check("r0_zero", rd_data_a, 32'h00000000);
        check("r31_value", rd_data_b, 32'h12345678);

        // Issue r5, r5, r9 then write r5.
        drive(0, 0, 0, 1, 5'd5, 0, 0);
        drive(0, 0, 0, 1, 5'd5, 0, 0);
        #3 check("cnt_issue5", 32'(busy_cnt), 32'd1);
        drive(0, 0, 0, 1, 5'd9, 0, 0);
        #3 check("cnt_issue5_again", 32'(busy_cnt), 32'd1);
        drive(1, 5'd5, 32'h0000_0005, 0, 0, 0, 0);
        #3 check("cnt_issue9", 32'(busy_cnt), 32'd2);
        drive(0, 0, 0, 0, 0, 5'd5, 5'd9);
        #3;
        check("cnt_write5", 32'(busy_cnt), 32'd1);
        check("busy_r5", 32'(busy_a), 32'd0);
        check("busy_r9", 32'(busy_b), 32'd1);

        // Retire r9, then same-edge issue and write of r7.
        drive(1, 5'd9, 32'h0, 0, 0, 0, 0);
        drive(1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 0, 0);
        drive(0, 0, 0, 0, 0, 5'd7, 0);
        #3;
        check("r7_data", rd_data_a, 32'hA5A5A5A5);
        check("r7_busy", 32'(busy_a), 32'd1);
        check("r7_cnt", 32'(busy_cnt), 32'd1);

        // Forwarding on r3.
        drive(1, 5'd3, 32'h11, 0, 0, 0, 0);
        drive(1, 5'd3, 32'h55, 0, 0, 5'd3, 0);
        #3 check("bypass_same_cycle", rd_data_a, BYPASS ? 32'h55 : 32'h11);
        drive(0, 0, 0, 0, 0, 5'd3, 0);
        #3 check("bypass_next_cycle", rd_data_a, 32'h55);

        // Build busy_cnt to 4, then reset mid-cycle with a write in flight.
        drive(0, 0, 0, 1, 5'd10, 0, 0);
        drive(0, 0, 0, 1, 5'd11, 0, 0);
        drive(0, 0, 0, 1, 5'd12, 0, 0);
        drive(0, 0, 0, 0, 0, 5'd7, 5'd10);
        #3 check("cnt_before_reset", 32'(busy_cnt), 32'd4);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h99;
        rd_addr_a = 5'd2; rd_addr_b = 5'd10;
        #1;
        check("rst_data_a", rd_data_a, 32'd0);
        check("rst_data_b", rd_data_b, 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_cnt_async", 32'(busy_cnt), 32'd0);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rst_n = 1'b1;
        #3 check("rst_write_discarded", rd_data_a, 32'd0);
        drive(1, 5'd2, 32'h1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5'd2);
        #3 check("post_reset_write", rd_data_b, 32'h1);

        // Randomised traffic; addresses biased to a small set for collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [ADDR_W-1:0] wa, ia, ra, rb;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ia = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 2) == 0) ? ia : 5'($urandom);
            drive(1'($urandom_range(0, 1)), wa, $urandom,
                  ($urandom_range(0, 2) != 0), ia, ra, rb);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
